// File: rtl/ttm4_pkg.sv
// Shared definitions for the TTM4 control sequencer: state encoding and opcodes.
package ttm4_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

endpackage

// File: rtl/step_sync.sv
// Two-flop synchronizer plus rising-edge detector for the STEP push-button.
module step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic step_i,
  output logic step_rise_o
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [2:0] fill_q, fill_d;

  always_comb begin
    sync1_d = step_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = {fill_q[1:0], 1'b1};
    // Edges are suppressed until prev_q holds a real post-reset sample, so a
    // button already held at reset release does not look like a press.
    step_rise_o = sync2_q & ~prev_q & fill_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// TTM4 control sequencer: WAIT/FETCH/EXEC/WB FSM with bus-source and load-strobe decode.
module control_sequencer
  import ttm4_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic [3:0] OPCODE,
  input  logic       CARRY_IN,
  output logic       nA_OUT,
  output logic       nB_OUT,
  output logic       nIN_OUT,
  output logic       nA_ST,
  output logic       nB_ST,
  output logic       nOUT_ST,
  output logic       nPC_LD,
  output logic       PC_INC,
  output logic       CFLAG,
  output logic [1:0] PHASE
);

  state_e     state_q, state_d;
  logic [3:0] ir_q, ir_d;
  logic       cflag_q, cflag_d;
  logic       step_rise;

  logic src_a, src_b, src_in;
  logic dst_a, dst_b, dst_out;
  logic jump_taken, busy;

  step_sync u_step_sync (
    .clk         (CLK),
    .rst_n       (RST),
    .step_i      (STEP),
    .step_rise_o (step_rise)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cflag_d = cflag_q;
    unique case (state_q)
      ST_WAIT:  if (RUN || step_rise) state_d = ST_FETCH;
      ST_FETCH: begin
        state_d = ST_EXEC;
        ir_d    = OPCODE;
      end
      ST_EXEC:  state_d = ST_WB;
      ST_WB: begin
        cflag_d = CARRY_IN;
        state_d = RUN ? ST_FETCH : ST_WAIT;
      end
      default:  state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    src_a   = 1'b0;
    src_b   = 1'b0;
    src_in  = 1'b0;
    dst_a   = 1'b0;
    dst_b   = 1'b0;
    dst_out = 1'b0;
    case (ir_q)
      OP_ADD_A_IM: begin src_a  = 1'b1; dst_a   = 1'b1; end
      OP_MOV_A_B:  begin src_b  = 1'b1; dst_a   = 1'b1; end
      OP_IN_A:     begin src_in = 1'b1; dst_a   = 1'b1; end
      OP_MOV_A_IM: dst_a = 1'b1;
      OP_MOV_B_A:  begin src_a  = 1'b1; dst_b   = 1'b1; end
      OP_ADD_B_IM: begin src_b  = 1'b1; dst_b   = 1'b1; end
      OP_IN_B:     begin src_in = 1'b1; dst_b   = 1'b1; end
      OP_MOV_B_IM: dst_b = 1'b1;
      OP_OUT_B:    begin src_b  = 1'b1; dst_out = 1'b1; end
      OP_OUT_IM:   dst_out = 1'b1;
      default:     ;
    endcase
    // JNC tests the flag as held before the WB edge updates it.
    jump_taken = (ir_q == OP_JMP) || ((ir_q == OP_JNC) && !cflag_q);
    busy       = (state_q == ST_EXEC) || (state_q == ST_WB);

    nA_OUT  = 1'b1;
    nB_OUT  = 1'b1;
    nIN_OUT = 1'b1;
    nA_ST   = 1'b1;
    nB_ST   = 1'b1;
    nOUT_ST = 1'b1;
    nPC_LD  = 1'b1;
    PC_INC  = 1'b0;
    if (busy) begin
      nA_OUT  = ~src_a;
      nB_OUT  = ~src_b;
      nIN_OUT = ~src_in;
    end
    if (state_q == ST_WB) begin
      nA_ST   = ~dst_a;
      nB_ST   = ~dst_b;
      nOUT_ST = ~dst_out;
      nPC_LD  = ~jump_taken;
      PC_INC  = ~jump_taken;
    end
    CFLAG = cflag_q;
    PHASE = state_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
      cflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cflag_q <= cflag_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

  logic       CLK, RST, RUN, STEP, CARRY_IN;
  logic [3:0] OPCODE;
  logic       nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC, CFLAG;
  logic [1:0] PHASE;
  logic [7:0] outs;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  localparam logic [7:0] IDLE = 8'hFE;

  control_sequencer dut (
    .CLK      (CLK),
    .RST      (RST),
    .RUN      (RUN),
    .STEP     (STEP),
    .OPCODE   (OPCODE),
    .CARRY_IN (CARRY_IN),
    .nA_OUT   (nA_OUT),
    .nB_OUT   (nB_OUT),
    .nIN_OUT  (nIN_OUT),
    .nA_ST    (nA_ST),
    .nB_ST    (nB_ST),
    .nOUT_ST  (nOUT_ST),
    .nPC_LD   (nPC_LD),
    .PC_INC   (PC_INC),
    .CFLAG    (CFLAG),
    .PHASE    (PHASE)
  );

  // {nA_OUT,nB_OUT,nIN_OUT,nA_ST,nB_ST,nOUT_ST,nPC_LD,PC_INC}
  assign outs = {nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD, PC_INC};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge while in FETCH; leaves at the negedge after WB.
  task automatic do_instr(input string tag, input logic [3:0] op, input logic cin,
                          input logic run_exec, input logic step_exec,
                          input logic [7:0] exp_exec, input logic [7:0] exp_wb,
                          input logic exp_cf, input logic [1:0] exp_after);
    OPCODE = op;
    STEP   = step_exec;
    chk({tag, "_fetch_ph"}, {6'd0, PHASE}, 8'd1);
    chk({tag, "_fetch_out"}, outs, IDLE);
    @(negedge CLK);
    RUN    = run_exec;
    OPCODE = ~op;
    chk({tag, "_exec_ph"}, {6'd0, PHASE}, 8'd2);
    chk({tag, "_exec_out"}, outs, exp_exec);
    @(negedge CLK);
    STEP     = 1'b0;
    CARRY_IN = cin;
    chk({tag, "_wb_ph"}, {6'd0, PHASE}, 8'd3);
    chk({tag, "_wb_out"}, outs, exp_wb);
    @(negedge CLK);
    chk({tag, "_cflag"}, {7'd0, CFLAG}, {7'd0, exp_cf});
    chk({tag, "_next_ph"}, {6'd0, PHASE}, {6'd0, exp_after});
    chk({tag, "_next_out"}, outs, IDLE);
  endtask

  initial begin
    RST = 1'b0; RUN = 1'b0; STEP = 1'b0; OPCODE = 4'h0; CARRY_IN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_ph", {6'd0, PHASE}, 8'd0);
    chk("rst_out", outs, IDLE);
    chk("rst_cf", {7'd0, CFLAG}, 8'd0);

    @(negedge CLK);
    RST = 1'b1;
    RUN = 1'b1;
    @(negedge CLK);
    //        tag      op       cin  run  stp  exec   wb     cf  after
    do_instr("movai", 4'b0011, 1'b0, 1'b1, 1'b0, 8'hFE, 8'hEF, 1'b0, 2'd1);
    do_instr("addbi", 4'b0101, 1'b1, 1'b1, 1'b0, 8'hBE, 8'hB7, 1'b1, 2'd1);
    do_instr("jnc_c1", 4'b1110, 1'b0, 1'b1, 1'b0, 8'hFE, 8'hFF, 1'b0, 2'd1);
    do_instr("jnc_c0", 4'b1110, 1'b1, 1'b1, 1'b0, 8'hFE, 8'hFC, 1'b1, 2'd1);
    do_instr("jmp",   4'b1111, 1'b0, 1'b1, 1'b0, 8'hFE, 8'hFC, 1'b0, 2'd1);
    do_instr("inb",   4'b0110, 1'b1, 1'b1, 1'b0, 8'hDE, 8'hD7, 1'b1, 2'd1);
    do_instr("outb",  4'b1001, 1'b0, 1'b1, 1'b0, 8'hBE, 8'hBB, 1'b0, 2'd1);
    do_instr("movba", 4'b0100, 1'b0, 1'b1, 1'b0, 8'h7E, 8'h77, 1'b0, 2'd1);
    do_instr("nop",   4'b1010, 1'b1, 1'b1, 1'b0, 8'hFE, 8'hFF, 1'b1, 2'd1);
    do_instr("outim", 4'b1011, 1'b0, 1'b1, 1'b0, 8'hFE, 8'hFB, 1'b0, 2'd1);
    // RUN drops during EXEC: instruction completes, then WAIT.
    do_instr("adda_rundrop", 4'b0000, 1'b1, 1'b0, 1'b0, 8'h7E, 8'h6F, 1'b1, 2'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("idle_ph", {6'd0, PHASE}, 8'd0);
    end

    // Single step: one short pulse, a second pulse held across EXEC is discarded.
    STEP = 1'b1;
    @(negedge CLK);
    STEP = 1'b0;
    chk("step_lat1", {6'd0, PHASE}, 8'd0);
    @(negedge CLK);
    chk("step_lat2", {6'd0, PHASE}, 8'd0);
    @(negedge CLK);
    do_instr("step_movab", 4'b0001, 1'b1, 1'b0, 1'b1, 8'hBE, 8'hAF, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("step_no_second", {6'd0, PHASE}, 8'd0);
    end

    // Reset during EXEC of OUT B.
    RUN = 1'b1;
    @(negedge CLK);
    chk("rstx_fetch_ph", {6'd0, PHASE}, 8'd1);
    OPCODE = 4'b1001;
    @(negedge CLK);
    chk("rstx_exec_ph", {6'd0, PHASE}, 8'd2);
    chk("rstx_exec_out", outs, 8'hBE);
    #2;
    RST = 1'b0; RUN = 1'b0; STEP = 1'b1; CARRY_IN = 1'b1;
    #1;
    chk("rstx_async_ph", {6'd0, PHASE}, 8'd0);
    chk("rstx_async_out", outs, IDLE);
    chk("rstx_async_cf", {7'd0, CFLAG}, 8'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("rstx_hold_out", outs, IDLE);
    end

    // Release reset with STEP held high: no launch.
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("held_step_ph", {6'd0, PHASE}, 8'd0);
    end
    STEP = 1'b0;
    @(negedge CLK);
    STEP = 1'b1;
    repeat (3) @(negedge CLK);
    chk("post_rst_step_ph", {6'd0, PHASE}, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, ports listed first: CLK input 1 clock, rising edge; RST input 1 asynchronous active-low reset.
REQ-002 RUN input 1: 1 = free-running instruction execution; 0 = single-step mode.
REQ-003 STEP input 1: asynchronous push-button level; a rising edge launches one instruction in single-step mode.
REQ-004 OPCODE input 4: upper nibble of the current ROM word.
REQ-005 CARRY_IN input 1: carry-out of the 4-bit adder feeding register STOREDATA.
REQ-006 nA_OUT, nB_OUT, nIN_OUT outputs 1 each: active-low bus-source enables for register A, register B and the input port; none asserted = bus reads zero.
REQ-007 nA_ST, nB_ST, nOUT_ST, nPC_LD outputs 1 each: active-low load strobes for A, B, the output port and the PC.
REQ-008 PC_INC output 1: active-high PC count enable.
REQ-009 CFLAG output 1: registered carry flag. PHASE output 2: current FSM state, for LED display.

Function
REQ-010 The FSM SHALL have states WAIT=0, FETCH=1, EXEC=2, WB=3, encoded on PHASE.
REQ-011 WAIT->FETCH when RUN=1 or a synchronized STEP rising edge occurs; otherwise stay in WAIT.
REQ-012 FETCH->EXEC unconditionally; the OPCODE is latched into the instruction register IR on this transition.
REQ-013 EXEC->WB unconditionally.
REQ-014 WB->FETCH if RUN=1; WB->WAIT if RUN=0.
REQ-015 Instruction latency SHALL be 3 cycles (FETCH, EXEC, WB); in RUN mode, one instruction retires every 3 cycles.
REQ-016 Source enables SHALL be asserted throughout both EXEC and WB from the IR decode: ADD A,Im(0000)/MOV B,A(0100)->nA_OUT; ADD B,Im(0101)/MOV A,B(0001)/OUT B(1001)->nB_OUT; IN A(0010)/IN B(0110)->nIN_OUT; MOV A,Im(0011), MOV B,Im(0111), OUT Im(1011), JMP(1111), JNC(1110)->none.
REQ-017 Load strobes SHALL be low for exactly one cycle, in WB only: destination A for 0000/0001/0010/0011; destination B for 0100/0101/0110/0111; output port for 1001/1011.
REQ-018 nPC_LD SHALL be low in WB for JMP, and for JNC when CFLAG=0; PC_INC SHALL be high in WB for every other instruction; the two are mutually exclusive.
REQ-019 For JNC, the CFLAG value sampled SHALL be the value held before the WB edge.
REQ-020 On the WB clock edge, CFLAG SHALL take CARRY_IN for every instruction, including jumps and NOPs.
REQ-021 Undefined opcodes SHALL execute as NOP: no source enable, no store strobe, PC_INC=1, CFLAG updated.
REQ-022 STEP SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-023 A STEP edge arriving outside WAIT SHALL be discarded, not queued.
REQ-024 A RUN change mid-instruction SHALL take effect only at the WB->next-state decision; an instruction that has started always completes.

Reset
REQ-025 While RST=0, the module SHALL hold: state=WAIT, IR=0000, CFLAG=0, synchronizer and edge flops=0, all active-low outputs=1, PC_INC=0.
REQ-026 Reset asserted mid-instruction SHALL abort the instruction immediately, with no strobe emitted.
REQ-027 On RST release, a STEP held high SHALL NOT produce an edge.

Structure
REQ-028 The package ttm4_pkg SHALL hold the opcode constants and the state encoding.
REQ-029 The synchronizer and edge detector SHALL be a separate sub-module named step_sync; all other logic SHALL be flat.

Verification
REQ-030 RUN=1, OPCODE=0011 -> PHASE 1,2,3; in WB, nA_ST low for 1 cycle, no source enable, PC_INC=1.
REQ-031 RUN=1, OPCODE=0101, CARRY_IN=1 in WB -> nB_OUT low in EXEC and WB, nB_ST low in WB, CFLAG=1 after WB.
REQ-032 CFLAG=1, JNC (1110) -> PC_INC=1, nPC_LD stays high; repeated with CFLAG=0 -> nPC_LD low in WB, PC_INC=0.
REQ-033 RUN=0, two STEP pulses (second during EXEC) -> exactly one instruction executes, FSM returns to WAIT.
REQ-034 RST asserted during EXEC of OPCODE 1001 -> nOUT_ST never asserted, all outputs at reset values, CFLAG=0.
REQ-035 RUN dropped during EXEC of OPCODE 0000 -> instruction completes (nA_ST pulses), then FSM enters WAIT.
